// File: rtl/call_request_panel_if.sv
// Signal bundle between the call-request panel, the raw button inputs and the
// elevator controller. The panel sits on the slave side.
interface call_request_panel_if;
    logic [3:0] btn_car;
    logic [2:0] btn_hall_up;
    logic [2:0] btn_hall_dn;
    logic [1:0] floor;
    logic       up;
    logic       down;
    logic       door_open;

    logic [3:0] car_req;
    logic [2:0] hall_up_req;
    logic [2:0] hall_dn_req;
    logic       any_req;
    logic [1:0] target_floor;
    logic       target_valid;

    modport slave (
        input  btn_car, btn_hall_up, btn_hall_dn, floor, up, down, door_open,
        output car_req, hall_up_req, hall_dn_req, any_req, target_floor, target_valid
    );

    modport master (
        output btn_car, btn_hall_up, btn_hall_dn, floor, up, down, door_open,
        input  car_req, hall_up_req, hall_dn_req, any_req, target_floor, target_valid
    );
endinterface

// File: rtl/call_request_panel.sv
// Four-floor call-request panel: synchronizes and debounces ten raw buttons,
// latches requests, clears them on door-open service and picks the next target.
module call_request_panel #(
    parameter int DB_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    call_request_panel_if.slave  bus
);

    localparam int NBTN  = 10;
    localparam int CNT_W = 4;

    // Button vector layout: [3:0] car F1..F4, [6:4] hall-up F1..F3, [9:7] hall-down F2..F4
    logic [NBTN-1:0] raw;
    assign raw = {bus.btn_hall_dn, bus.btn_hall_up, bus.btn_car};

    logic [NBTN-1:0]             sync1_q, sync2_q;
    logic [NBTN-1:0]             db_q, db_d, db_prev_q;
    logic [NBTN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NBTN-1:0]             rise;

    logic [3:0] car_q, car_d;
    logic [2:0] hu_q, hu_d;
    logic [2:0] hd_q, hd_d;
    logic       any_q, any_d;
    logic [1:0] tf_q, tf_d;
    logic       tv_q, tv_d;

    logic       up_e, dn_e;
    logic [3:0] car_clr;
    logic [2:0] hu_clr, hd_clr;
    logic [3:0] req_vec;
    logic [2:0] pick;

    // Returns {valid, floor}; valid=0 when nothing but the current floor (or nothing) is requested
    // while travelling, or nothing at all while idle.
    function automatic logic [2:0] pick_target(
        input logic [3:0] r,
        input logic [1:0] cur,
        input logic       go_up,
        input logic       go_dn
    );
        logic       found;
        logic [1:0] tgt;
        int         c;
        found = 1'b0;
        tgt   = cur;
        c     = int'(cur);
        if (go_up) begin
            for (int f = 3; f >= 0; f--) begin
                if (f > c && r[f]) begin found = 1'b1; tgt = 2'(f); end
            end
            if (!found) begin
                for (int f = 0; f < 4; f++) begin
                    if (f < c && r[f]) begin found = 1'b1; tgt = 2'(f); end
                end
            end
        end else if (go_dn) begin
            for (int f = 0; f < 4; f++) begin
                if (f < c && r[f]) begin found = 1'b1; tgt = 2'(f); end
            end
            if (!found) begin
                for (int f = 3; f >= 0; f--) begin
                    if (f > c && r[f]) begin found = 1'b1; tgt = 2'(f); end
                end
            end
        end else if (r[cur]) begin
            found = 1'b1;
        end else begin
            // Farthest distance first so the nearest overwrites; lower side last wins ties.
            for (int d = 3; d >= 1; d--) begin
                if (c + d <= 3) begin
                    if (r[c + d]) begin found = 1'b1; tgt = 2'(c + d); end
                end
                if (c - d >= 0) begin
                    if (r[c - d]) begin found = 1'b1; tgt = 2'(c - d); end
                end
            end
        end
        return {found, tgt};
    endfunction

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NBTN; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign rise = db_q & ~db_prev_q;

    // Both direction inputs high is treated as idle.
    assign up_e = bus.up & ~bus.down;
    assign dn_e = bus.down & ~bus.up;

    always_comb begin
        car_clr = '0;
        hu_clr  = '0;
        hd_clr  = '0;
        if (bus.door_open) begin
            car_clr = 4'b0001 << bus.floor;
            for (int f = 0; f < 3; f++) begin
                if (bus.floor == 2'(f) && !dn_e) hu_clr[f] = 1'b1;
                if (bus.floor == 2'(f + 1) && !up_e) hd_clr[f] = 1'b1;
            end
        end
    end

    assign car_d = (car_q | rise[3:0]) & ~car_clr;
    assign hu_d  = (hu_q  | rise[6:4]) & ~hu_clr;
    assign hd_d  = (hd_q  | rise[9:7]) & ~hd_clr;

    assign req_vec = car_q | {1'b0, hu_q} | {hd_q, 1'b0};
    assign pick    = pick_target(req_vec, bus.floor, up_e, dn_e);

    always_comb begin
        any_d = |{car_q, hu_q, hd_q};
        tv_d  = pick[2];
        tf_d  = pick[2] ? pick[1:0] : tf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '0;
            car_q     <= '0;
            hu_q      <= '0;
            hd_q      <= '0;
            any_q     <= 1'b0;
            tf_q      <= 2'd0;
            tv_q      <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
            car_q     <= car_d;
            hu_q      <= hu_d;
            hd_q      <= hd_d;
            any_q     <= any_d;
            tf_q      <= tf_d;
            tv_q      <= tv_d;
        end
    end

    assign bus.car_req      = car_q;
    assign bus.hall_up_req  = hu_q;
    assign bus.hall_dn_req  = hd_q;
    assign bus.any_req      = any_q;
    assign bus.target_floor = tf_q;
    assign bus.target_valid = tv_q;

endmodule

// File: tb/tb_call_request_panel.sv
// Directed bench for call_request_panel: expectations are queued as stimulus is
// driven and popped against the outputs after the relevant clock edges.
module tb_call_request_panel;

    logic clk;
    logic reset;

    call_request_panel_if bif ();

    call_request_panel #(.DB_CYCLES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation word: {any, tv, tf[1:0], hd[2:0], hu[2:0], car[3:0]}
    localparam logic [13:0] M_CAR = 14'h000F;
    localparam logic [13:0] M_HU  = 14'h0070;
    localparam logic [13:0] M_HD  = 14'h0380;
    localparam logic [13:0] M_TF  = 14'h0C00;
    localparam logic [13:0] M_TV  = 14'h1000;
    localparam logic [13:0] M_ANY = 14'h2000;
    localparam logic [13:0] M_ALL = 14'h3FFF;

    typedef struct {
        string       tag;
        logic [13:0] mask;
        logic [13:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [13:0] obs();
        return {bif.any_req, bif.target_valid, bif.target_floor,
                bif.hall_dn_req, bif.hall_up_req, bif.car_req};
    endfunction

    function automatic logic [13:0] pk(input logic a, input logic v, input logic [1:0] tf,
                                       input logic [2:0] hd, input logic [2:0] hu,
                                       input logic [3:0] car);
        return {a, v, tf, hd, hu, car};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [13:0] mask, input logic [13:0] val);
        exp_t e;
        e.tag  = tag;
        e.mask = mask;
        e.val  = val & mask;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t        e;
        logic [13:0] o;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%h expected=queued_entry", obs());
        end else begin
            e = sb.pop_front();
            o = obs() & e.mask;
            assert (o === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        bif.btn_car     = '0;
        bif.btn_hall_up = '0;
        bif.btn_hall_dn = '0;
        bif.floor       = 2'd0;
        bif.up          = 1'b0;
        bif.down        = 1'b0;
        bif.door_open   = 1'b0;

        push("rst_state", M_ALL, 14'h0);
        tick(2);
        check_pop();
        reset = 1'b0;

        // Car F3 held from edge 0: request on edge 5, target on edge 6
        bif.btn_car = 4'b0100;
        push("t1_edge4", M_CAR, 14'h0);
        tick(5);
        check_pop();
        push("t1_edge5", M_CAR | M_TV | M_ANY, pk(0, 0, 0, 0, 0, 4'b0100));
        tick(1);
        check_pop();
        push("t1_edge6", M_ALL, pk(1, 1, 2'd2, 0, 0, 4'b0100));
        tick(1);
        check_pop();

        bif.btn_car   = 4'b0000;
        bif.floor     = 2'd2;
        bif.door_open = 1'b1;
        push("t1_clear", M_CAR, 14'h0);
        tick(1);
        check_pop();
        bif.door_open = 1'b0;
        push("t1_hold", M_ALL, pk(0, 0, 2'd2, 0, 0, 0));
        tick(1);
        check_pop();

        // Short pulse: two synchronized samples only
        bif.floor       = 2'd0;
        bif.btn_hall_up = 3'b010;
        tick(2);
        bif.btn_hall_up = 3'b000;
        push("t2_pulse", M_HU | M_ANY, 14'h0);
        tick(8);
        check_pop();

        // Direction-based selection with car_req = 1010
        bif.btn_car = 4'b1010;
        push("t3_set", M_CAR, pk(0, 0, 0, 0, 0, 4'b1010));
        tick(6);
        check_pop();
        bif.btn_car = 4'b0000;
        bif.floor   = 2'd2;
        bif.up      = 1'b1;
        push("t3_up", M_TF | M_TV, pk(0, 1, 2'd3, 0, 0, 0));
        tick(1);
        check_pop();
        bif.up   = 1'b0;
        bif.down = 1'b1;
        push("t3_down", M_TF | M_TV, pk(0, 1, 2'd1, 0, 0, 0));
        tick(1);
        check_pop();
        bif.down = 1'b0;
        push("t3_idle_tie", M_TF | M_TV, pk(0, 1, 2'd1, 0, 0, 0));
        tick(1);
        check_pop();
        bif.floor = 2'd3;
        bif.up    = 1'b1;
        push("t3_up_top", M_TF | M_TV, pk(0, 1, 2'd1, 0, 0, 0));
        tick(1);
        check_pop();
        bif.floor = 2'd0;
        bif.up    = 1'b0;
        bif.down  = 1'b1;
        push("t3_down_bottom", M_TF | M_TV, pk(0, 1, 2'd1, 0, 0, 0));
        tick(1);
        check_pop();
        bif.floor = 2'd2;
        bif.up    = 1'b1;
        bif.down  = 1'b1;
        push("t3_both_idle", M_TF | M_TV, pk(0, 1, 2'd1, 0, 0, 0));
        tick(1);
        check_pop();

        bif.up        = 1'b0;
        bif.down      = 1'b0;
        bif.floor     = 2'd1;
        bif.door_open = 1'b1;
        push("t3_clr_f2", M_CAR, pk(0, 0, 0, 0, 0, 4'b1000));
        tick(1);
        check_pop();
        bif.floor = 2'd3;
        push("t3_clr_f4", M_CAR, 14'h0);
        tick(1);
        check_pop();
        bif.door_open = 1'b0;

        // Hall calls at floor 3 in both directions, cleared by direction
        bif.floor       = 2'd0;
        bif.btn_hall_up = 3'b100;
        bif.btn_hall_dn = 3'b010;
        push("t4_set", M_HU | M_HD, pk(0, 0, 0, 3'b010, 3'b100, 0));
        tick(6);
        check_pop();
        bif.btn_hall_up = 3'b000;
        bif.btn_hall_dn = 3'b000;
        bif.floor       = 2'd2;
        bif.up          = 1'b1;
        push("t4_only_current", M_TV | M_TF, pk(0, 0, 2'd3, 0, 0, 0));
        tick(1);
        check_pop();
        bif.door_open = 1'b1;
        push("t4_up_clear", M_HU | M_HD, pk(0, 0, 0, 3'b010, 3'b000, 0));
        tick(1);
        check_pop();
        bif.up   = 1'b0;
        bif.down = 1'b1;
        push("t4_down_clear", M_HD, 14'h0);
        tick(1);
        check_pop();
        bif.door_open = 1'b0;
        bif.down      = 1'b0;

        // Debounced rise coinciding with door open at that floor
        bif.floor   = 2'd0;
        bif.btn_car = 4'b0001;
        tick(5);
        bif.door_open = 1'b1;
        push("t5_clear_wins", M_CAR, 14'h0);
        tick(1);
        check_pop();
        bif.door_open = 1'b0;
        push("t5_no_reset", M_CAR | M_ANY, 14'h0);
        tick(4);
        check_pop();
        bif.btn_car = 4'b0000;
        tick(6);

        // Reset while requests latched and buttons still held
        bif.floor       = 2'd1;
        bif.btn_car     = 4'b1000;
        bif.btn_hall_up = 3'b001;
        push("t6_set", M_CAR | M_HU, pk(0, 0, 0, 0, 3'b001, 4'b1000));
        tick(6);
        check_pop();
        push("t6_target", M_TF | M_TV | M_ANY, pk(1, 1, 2'd0, 0, 0, 0));
        tick(1);
        check_pop();
        reset = 1'b1;
        push("t6_reset", M_ALL, 14'h0);
        tick(1);
        check_pop();
        reset = 1'b0;
        push("t6_post_edge4", M_CAR | M_HU, 14'h0);
        tick(5);
        check_pop();
        push("t6_post_edge5", M_CAR | M_HU, pk(0, 0, 0, 0, 3'b001, 4'b1000));
        tick(1);
        check_pop();
        bif.btn_car     = 4'b0000;
        bif.btn_hall_up = 3'b000;

        // Reset in the middle of a debounce leaves nothing behind
        reset = 1'b1;
        tick(1);
        reset       = 1'b0;
        bif.btn_car = 4'b0010;
        tick(3);
        reset       = 1'b1;
        bif.btn_car = 4'b0000;
        tick(1);
        reset = 1'b0;
        push("t7_mid_debounce", M_ALL, 14'h0);
        tick(8);
        check_pop();

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
